ringbuffer_ctrl: RTL and testbench

Clocked, parametrised pointer and flag controller for a power-of-two ring buffer whose storage is a separate RAM. It tracks write and read addresses, fill level and full/empty state, and handles overflow in one of two selectable policies. It sits between the LPC frame capture logic (producer, pulses `write_done` per stored record) and the UART drain logic (consumer, pulses `read_done` per record sent). Unlike the previous pointer logic, it is fully synchronous, uses all 2^BITS slots, and counts dropped records.

---
 rtl/ringbuffer_ctrl_pkg.sv | 9 +
 rtl/ringbuffer_ctrl_sat_counter.sv | 32 +++
 rtl/ringbuffer_ctrl.sv | 96 +++++++++
 tb/tb_ringbuffer_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ringbuffer_ctrl_pkg.sv
// ringbuffer_ctrl_pkg: shared constants for the ring buffer controller
// and the saturating counter it uses for dropped-record accounting.
package ringbuffer_ctrl_pkg;

  localparam int RB_MODE_DROP      = 0;
  localparam int RB_MODE_OVERWRITE = 1;
  localparam int RB_DROP_W         = 8;

endpackage

// File: rtl/ringbuffer_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Clear and increment in the same cycle yields a count of one.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] nxt;

  // Clear first, then apply a saturating increment.
  always_comb begin
    base = clr ? '0 : count;
    nxt  = base;
    if (inc && (base != {WIDTH{1'b1}}))
      nxt = base + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else
      count <= nxt;
  end

endmodule

// File: rtl/ringbuffer_ctrl.sv
// ringbuffer_ctrl: pointer, level and flag tracking for a 2^BITS ring
// buffer with drop-newest or overwrite-oldest overflow handling.
module ringbuffer_ctrl
  import ringbuffer_ctrl_pkg::*;
#(
  parameter int BITS        = 5,
  parameter int MODE        = RB_MODE_DROP,
  parameter int AFULL_LEVEL = (1 << BITS) - 2,
  parameter int DROP_W      = RB_DROP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_done,
  input  logic              read_done,
  input  logic              overflow_clear,
  output logic [BITS-1:0]   write_addr,
  output logic [BITS-1:0]   read_addr,
  output logic [BITS:0]     level,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam logic [BITS:0] DEPTH = {1'b1, {BITS{1'b0}}};
  localparam logic [BITS:0] AFULL = (BITS+1)'(AFULL_LEVEL);

  logic [BITS:0] wptr;
  logic [BITS:0] rptr;
  logic          wadv;
  logic          radv;
  logic          drop;

  assign level       = wptr - rptr;
  assign empty       = (level == '0);
  assign full        = (level == DEPTH);
  assign almost_full = (level >= AFULL);
  assign write_addr  = wptr[BITS-1:0];
  assign read_addr   = rptr[BITS-1:0];

  // Decide pointer moves and drops from the registered full/empty state.
  always_comb begin
    wadv = 1'b0;
    radv = 1'b0;
    drop = 1'b0;
    if (write_done && !read_done) begin
      if (!full) begin
        wadv = 1'b1;
      end else if (MODE == RB_MODE_OVERWRITE) begin
        wadv = 1'b1;
        radv = 1'b1;
        drop = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (read_done && !write_done) begin
      radv = !empty;
    end else if (write_done && read_done) begin
      wadv = 1'b1;
      radv = !empty;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wadv) wptr <= wptr + 1'b1;
      if (radv) rptr <= rptr + 1'b1;
    end
  end

  // Sticky overflow flag; a drop wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (overflow_clear)
      overflow <= 1'b0;
  end

  sat_counter #(
    .WIDTH (DROP_W)
  ) u_drops (
    .clk   (clk),
    .reset (reset),
    .inc   (drop),
    .clr   (overflow_clear),
    .count (drop_count)
  );

endmodule

// File: tb/tb_ringbuffer_ctrl.sv
// tb_ringbuffer_ctrl: directed vector table on a drop-mode instance plus
// hand sequences on an overwrite-mode instance.
module tb_ringbuffer_ctrl;

  typedef struct {
    logic       rst, w, r, c;
    logic [1:0] wa, ra;
    logic [2:0] lv;
    logic       e, f, a, o;
    logic [1:0] d;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       rst0 = 1'b0, w0 = 1'b0, r0 = 1'b0, c0 = 1'b0;
  logic [1:0] wa0, ra0, d0;
  logic [2:0] lv0;
  logic       e0, f0, a0, o0;

  logic       rst1 = 1'b0, w1 = 1'b0, r1 = 1'b0, c1 = 1'b0;
  logic [1:0] wa1, ra1;
  logic [2:0] lv1;
  logic       e1, f1, a1, o1;
  logic [7:0] d1;

  ringbuffer_ctrl #(
    .BITS(2), .MODE(0), .AFULL_LEVEL(3), .DROP_W(2)
  ) dut0 (
    .clk(clk), .reset(rst0), .write_done(w0), .read_done(r0),
    .overflow_clear(c0), .write_addr(wa0), .read_addr(ra0),
    .level(lv0), .empty(e0), .full(f0), .almost_full(a0),
    .overflow(o0), .drop_count(d0)
  );

  ringbuffer_ctrl #(
    .BITS(2), .MODE(1)
  ) dut1 (
    .clk(clk), .reset(rst1), .write_done(w1), .read_done(r1),
    .overflow_clear(c1), .write_addr(wa1), .read_addr(ra1),
    .level(lv1), .empty(e1), .full(f1), .almost_full(a1),
    .overflow(o1), .drop_count(d1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input int rst, w, r, c, wa, ra, lv, e, f, a, o, d
  );
    vec_t v;
    v.rst = rst[0]; v.w = w[0]; v.r = r[0]; v.c = c[0];
    v.wa = wa[1:0]; v.ra = ra[1:0]; v.lv = lv[2:0];
    v.e = e[0]; v.f = f[0]; v.a = a[0]; v.o = o[0];
    v.d = d[1:0];
    return v;
  endfunction

  task automatic step1(input logic rs, input logic w, input logic r);
    @(negedge clk);
    rst1 = rs; w1 = w; r1 = r;
    @(posedge clk);
    #2;
    rst1 = 1'b0; w1 = 1'b0; r1 = 1'b0;
  endtask

  vec_t tv[25];

  initial begin
    //            rst w r c  wa ra lv  e f a o  d
    tv[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tv[1]  = mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 1, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0);
    tv[3]  = mk(0, 1, 0, 0, 3, 0, 3, 0, 0, 1, 0, 0);
    tv[4]  = mk(0, 1, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0);
    tv[5]  = mk(0, 1, 0, 0, 0, 0, 4, 0, 1, 1, 1, 1);
    tv[6]  = mk(0, 1, 0, 0, 0, 0, 4, 0, 1, 1, 1, 2);
    tv[7]  = mk(0, 1, 0, 0, 0, 0, 4, 0, 1, 1, 1, 3);
    tv[8]  = mk(0, 1, 0, 0, 0, 0, 4, 0, 1, 1, 1, 3);
    tv[9]  = mk(0, 1, 0, 0, 0, 0, 4, 0, 1, 1, 1, 3);
    tv[10] = mk(0, 1, 0, 1, 0, 0, 4, 0, 1, 1, 1, 1);
    tv[11] = mk(0, 0, 0, 1, 0, 0, 4, 0, 1, 1, 0, 0);
    tv[12] = mk(0, 1, 1, 0, 1, 1, 4, 0, 1, 1, 0, 0);
    tv[13] = mk(0, 0, 1, 0, 1, 2, 3, 0, 0, 1, 0, 0);
    tv[14] = mk(0, 0, 1, 0, 1, 3, 2, 0, 0, 0, 0, 0);
    tv[15] = mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tv[16] = mk(0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    tv[17] = mk(0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    tv[18] = mk(0, 1, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0);
    tv[19] = mk(0, 0, 1, 0, 2, 2, 0, 1, 0, 0, 0, 0);
    tv[20] = mk(0, 1, 0, 0, 3, 2, 1, 0, 0, 0, 0, 0);
    tv[21] = mk(0, 1, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0);
    tv[22] = mk(0, 1, 0, 0, 1, 2, 3, 0, 0, 1, 0, 0);
    tv[23] = mk(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tv[24] = mk(0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      rst0 = tv[i].rst; w0 = tv[i].w; r0 = tv[i].r; c0 = tv[i].c;
      @(posedge clk);
      #2;
      rst0 = 1'b0; w0 = 1'b0; r0 = 1'b0; c0 = 1'b0;
      if (wa0 != tv[i].wa || ra0 != tv[i].ra || lv0 != tv[i].lv ||
          e0 != tv[i].e || f0 != tv[i].f || a0 != tv[i].a ||
          o0 != tv[i].o || d0 != tv[i].d) begin
        $display("FAIL vec%0d: got wa=%0d ra=%0d lv=%0d e=%0b f=%0b a=%0b o=%0b d=%0d expected wa=%0d ra=%0d lv=%0d e=%0b f=%0b a=%0b o=%0b d=%0d",
          i, wa0, ra0, lv0, e0, f0, a0, o0, d0,
          tv[i].wa, tv[i].ra, tv[i].lv, tv[i].e, tv[i].f,
          tv[i].a, tv[i].o, tv[i].d);
        bad++;
      end
      total++;
    end

    // Overwrite mode: six writes from empty.
    step1(1'b1, 1'b0, 1'b0);
    chk("ow_rst_empty", int'(e1), 1);
    for (int i = 0; i < 2; i++) step1(1'b0, 1'b1, 1'b0);
    chk("ow_afull_at2", int'(a1), 1);
    for (int i = 0; i < 4; i++) step1(1'b0, 1'b1, 1'b0);
    chk("ow_level", int'(lv1), 4);
    chk("ow_raddr", int'(ra1), 2);
    chk("ow_waddr", int'(wa1), 2);
    chk("ow_drops", int'(d1), 2);
    chk("ow_ovf", int'(o1), 1);

    // Full with simultaneous write and read: no drop.
    step1(1'b0, 1'b1, 1'b1);
    chk("wr_full_waddr", int'(wa1), 3);
    chk("wr_full_raddr", int'(ra1), 3);
    chk("wr_full_level", int'(lv1), 4);
    chk("wr_full_drops", int'(d1), 2);

    // Ten write/read pairs wrap the addresses twice.
    step1(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step1(1'b0, 1'b1, 1'b0);
      chk("pair_lv_le1", int'(lv1 <= 3'd1), 1);
      step1(1'b0, 1'b0, 1'b1);
      chk("pair_empty", int'(e1), 1);
    end
    chk("pair_waddr", int'(wa1), 2);
    chk("pair_raddr", int'(ra1), 2);
    chk("pair_ovf", int'(o1), 0);

    // Read while empty is ignored.
    step1(1'b0, 1'b0, 1'b1);
    chk("rd_empty_raddr", int'(ra1), 2);
    chk("rd_empty_level", int'(lv1), 0);
    chk("rd_empty_ovf", int'(o1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
